// File: rtl/core_pkg.sv
// Shared core definitions used by the fetch front end.
package core_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_BOOT,
        FS_FETCH,
        FS_DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries, push/pop/flush; a flush wins over any push in the same cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clock_i,
    input  logic                       reset_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop_i && (cnt_q != '0);
        do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
        rd_d    = rd_q + AW'(do_pop);
        wr_d    = wr_q + AW'(do_push);
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with prefetch FIFO and redirect draining.
// Optional FETCH_BYPASS_EN forwards a response straight to instr_o when the FIFO is empty.
module fetch_unit
    import core_pkg::*;
#(
    parameter int unsigned     DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clock_i,
    input  logic            reset_ni,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            instr_ready_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outst_q, outst_d, discard_q, discard_d;
    logic [XLEN-1:0] aq_q [DEPTH];
    logic [AW-1:0]   aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;

    fetch_entry_t    fifo_head, fifo_in;
    logic [CW-1:0]   fifo_cnt;
    logic            fifo_empty, fifo_push, fifo_pop;
    logic            rsp_live, accept, grant, bypass;

    // Responses with nothing outstanding (e.g. stragglers from before a reset) are ignored.
    always_comb begin
        rsp_live    = imem_rvalid_i && (outst_q != '0);
        imem_req_o  = (state_q == FS_FETCH) && !redirect_i &&
                      ((32'(outst_q) + 32'(fifo_cnt)) < DEPTH);
        imem_addr_o = {fetch_pc_q[XLEN-1:2], 2'b00};
        grant       = imem_req_o && imem_gnt_i;
        accept      = rsp_live && (state_q == FS_FETCH) && !redirect_i;
`ifdef FETCH_BYPASS_EN
        bypass      = accept && fifo_empty;
`else
        bypass      = 1'b0;
`endif
        instr_valid_o = !fifo_empty || bypass;
        instr_o       = NOP;
        instr_pc_o    = '0;
        if (!fifo_empty) begin
            instr_o    = fifo_head.instr;
            instr_pc_o = fifo_head.pc;
        end else if (bypass) begin
            instr_o    = imem_rdata_i;
            instr_pc_o = aq_q[aq_rd_q];
        end
        fifo_pop  = instr_ready_i && !fifo_empty;
        fifo_push = accept && !(bypass && instr_ready_i);
        fifo_in   = {imem_rdata_i, aq_q[aq_rd_q]};
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        outst_d    = outst_q + CW'(grant) - CW'(rsp_live);
        aq_wr_d    = aq_wr_q + AW'(grant);
        aq_rd_d    = aq_rd_q + AW'(rsp_live);
        if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
        if (redirect_i) begin
            // Everything still in flight belongs to the old path.
            fetch_pc_d = redirect_pc_i & ~32'h3;
            discard_d  = outst_q - CW'(rsp_live);
            state_d    = (discard_d != '0) ? FS_DRAIN : FS_FETCH;
        end else begin
            case (state_q)
                FS_BOOT:  state_d = FS_FETCH;
                FS_DRAIN: begin
                    discard_d = discard_q - CW'(rsp_live);
                    if (discard_d == '0) state_d = FS_FETCH;
                end
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= FS_BOOT;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            aq_rd_q    <= '0;
            aq_wr_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            aq_rd_q    <= aq_rd_d;
            aq_wr_q    <= aq_wr_d;
        end
    end

    // In-order address queue: one entry per granted request, retired by each response.
    always_ff @(posedge clock_i) begin
        if (grant) aq_q[aq_wr_q] <= imem_addr_o;
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .push_i   (fifo_push),
        .data_i   (fifo_in),
        .pop_i    (fifo_pop),
        .flush_i  (redirect_i),
        .data_o   (fifo_head),
        .empty_o  (fifo_empty),
        .count_o  (fifo_cnt)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a stream-level model.
module tb_fetch_unit;

    logic        clock_i, reset_ni, redirect_i, instr_ready_i;
    logic [31:0] redirect_pc_i, instr_o, instr_pc_o, imem_addr_o, imem_rdata_i;
    logic        instr_valid_o, imem_req_o, imem_gnt_i, imem_rvalid_i;

    fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clock_i       (clock_i),
        .reset_ni      (reset_ni),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_ready_i (instr_ready_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t        mq[$];          // memory: granted requests awaiting response
    logic [31:0] gq[$], pq[$];   // logs of granted addresses and popped pcs
    logic [31:0] exp_pc, exp_req, pend_addr;
    logic        pend, s_req, s_valid, s_gnt;
    logic [31:0] s_pc;
    int cyc, gnt_pct, rv_pct, rdy_pct, pops, grants, rvs;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One cycle: drive inputs, sample after settling, update the stream model, advance.
    task automatic step(input logic redir, input logic [31:0] rpc);
        redirect_i    = redir;
        redirect_pc_i = rpc;
        instr_ready_i = ($urandom_range(99) < rdy_pct);
        imem_gnt_i    = ($urandom_range(99) < gnt_pct);
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (mq.size() != 0 && mq[0].due <= cyc && $urandom_range(99) < rv_pct) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = memf(mq[0].addr);
            void'(mq.pop_front());
            rvs++;
        end
        #1;
        s_req = imem_req_o; s_valid = instr_valid_o; s_pc = instr_pc_o; s_gnt = 1'b0;
        if (instr_valid_o && instr_ready_i) begin
            chk("pop_pc", instr_pc_o, exp_pc);
            chk("pop_data", instr_o, memf(exp_pc));
            pq.push_back(instr_pc_o);
            exp_pc += 32'd4;
            pops++;
        end
        if (pend && !redir) begin
            chk("req_hold", imem_req_o, 1);
            chk("addr_hold", imem_addr_o, pend_addr);
        end
        if (redir) begin
            chk("req_in_redirect", imem_req_o, 0);
        end else if (imem_req_o && imem_gnt_i) begin
            chk("req_addr", imem_addr_o, exp_req);
            gq.push_back(imem_addr_o);
            mq.push_back('{addr: imem_addr_o, due: cyc + 1});
            exp_req += 32'd4;
            grants++;
            s_gnt = 1'b1;
        end
        pend      = imem_req_o && !imem_gnt_i && !redir;
        pend_addr = imem_addr_o;
        if (redir) begin
            exp_pc  = rpc & 32'hFFFF_FFFC;
            exp_req = rpc & 32'hFFFF_FFFC;
        end
        @(posedge clock_i); #1;
        cyc++;
    endtask

    task automatic model_reset();
        exp_pc = '0; exp_req = '0; pend = 1'b0; cyc = 0;
        pops = 0; grants = 0; rvs = 0;
        gq.delete(); pq.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, instr_valid_o, 0);
        chk({tag, "_req"}, imem_req_o, 0);
        chk({tag, "_addr"}, imem_addr_o, 32'h0);
        chk({tag, "_instr"}, instr_o, 32'h0000_0013);
        chk({tag, "_pc"}, instr_pc_o, 32'h0);
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        mq.delete();
        @(posedge clock_i); @(posedge clock_i); #1;
        chk_reset_outputs("rst");
        reset_ni = 1'b1;
        model_reset();
        #1;
        chk("boot_no_req", imem_req_o, 0);
    endtask

    task automatic wait_grants(input int n, input string tag);
        for (int i = 0; i < 20 && grants < n; i++) step(1'b0, '0);
        chk(tag, grants, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fg, fv, rv_at;
        int lat;

        // Reset release, full-rate memory: addresses and pcs 0,4,8; grant-to-valid latency.
        do_reset();
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
        fg = -1; fv = -1;
        for (int i = 0; i < 10; i++) begin
            int c;
            c = cyc;
            step(1'b0, '0);
            if (s_gnt && fg < 0) fg = c;
            if (s_valid && fv < 0) fv = c;
        end
        chk("t1_grants", gq.size() >= 3, 1);
        chk("t1_pops", pq.size() >= 3, 1);
        if (gq.size() >= 3) begin
            chk("t1_addr0", gq[0], 32'h0);
            chk("t1_addr1", gq[1], 32'h4);
            chk("t1_addr2", gq[2], 32'h8);
        end
        if (pq.size() >= 3) begin
            chk("t1_pc0", pq[0], 32'h0);
            chk("t1_pc1", pq[1], 32'h4);
            chk("t1_pc2", pq[2], 32'h8);
        end
`ifdef FETCH_BYPASS_EN
        lat = 1;
`else
        lat = 2;
`endif
        chk("t1_latency", fv - fg, lat);

        // Core stalled: exactly DEPTH grants, then request held low until a pop.
        do_reset();
        gnt_pct = 100; rv_pct = 100; rdy_pct = 0;
        for (int i = 0; i < 12; i++) step(1'b0, '0);
        chk("t2_grants", grants, 2);
        chk("t2_req_low", s_req, 0);
        rdy_pct = 100;
        step(1'b0, '0);
        chk("t2_pop_valid", s_valid, 1);
        rdy_pct = 0;
        for (int i = 0; i < 4; i++) step(1'b0, '0);
        chk("t2_resume", grants, 3);

        // Redirect with two outstanding: both dropped, next request at aligned target.
        do_reset();
        gnt_pct = 100; rv_pct = 0; rdy_pct = 0;
        wait_grants(2, "t3_setup");
        gq.delete(); rvs = 0;
        rv_pct = 100; rdy_pct = 100;
        step(1'b1, 32'h0000_0102);
        rv_at = -1;
        for (int i = 0; i < 10 && gq.size() == 0; i++) begin
            step(1'b0, '0);
            if (gq.size() != 0) rv_at = rvs;
        end
        chk("t3_got_req", gq.size() != 0, 1);
        if (gq.size() != 0) chk("t3_addr", gq[0], 32'h0000_0100);
        chk("t3_drained_first", rv_at, 2);
        for (int i = 0; i < 6; i++) step(1'b0, '0);
        chk("t3_first_pop", (pq.size() != 0) ? pq[0] : 32'hDEAD_BEEF, 32'h0000_0100);

        // Redirect coincident with rvalid and pop.
        do_reset();
        gnt_pct = 100; rv_pct = 0; rdy_pct = 0;
        wait_grants(2, "t4_setup");
        gnt_pct = 0; rv_pct = 100;
        step(1'b0, '0);
        rdy_pct = 100;
        step(1'b1, 32'h0000_0200);
        chk("t4_pop_valid", s_valid, 1);
        chk("t4_pop_pc", s_pc, 32'h0);
        rdy_pct = 0; rv_pct = 0;
        step(1'b0, '0);
        chk("t4_empty", s_valid, 0);

        // Fetch pc wraps past the top of the address space.
        do_reset();
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
        step(1'b0, '0);
        gq.delete();
        step(1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 10 && gq.size() < 2; i++) step(1'b0, '0);
        chk("t5_two_reqs", gq.size() >= 2, 1);
        if (gq.size() >= 2) begin
            chk("t5_addr_top", gq[0], 32'hFFFF_FFFC);
            chk("t5_addr_wrap", gq[1], 32'h0);
        end

        // Reset asserted mid-drain; stale responses afterwards must be ignored.
        do_reset();
        gnt_pct = 100; rv_pct = 0; rdy_pct = 0;
        wait_grants(2, "t6_setup");
        step(1'b1, 32'h0000_0400);
        chk("t6_draining_addr", imem_addr_o, 32'h0000_0400);
        reset_ni = 1'b0;
        #1;
        chk_reset_outputs("t6_async");
        @(posedge clock_i); #1;
        reset_ni = 1'b1;
        model_reset();
        gnt_pct = 0; rv_pct = 100; rdy_pct = 100;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0);
            chk("t6_no_capture", s_valid, 0);
        end

        // Random traffic with random redirects.
        do_reset();
        gnt_pct = 70; rv_pct = 60; rdy_pct = 60;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 4, $urandom);
        end
        chk("rand_progress", pops > 100, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
